serial_magnitude_comparator: RTL
================================

// Module: serial_magnitude_comparator
// PURPOSE
//  Multi-cycle magnitude comparator for wide operands, MSB-first, DIGIT bits per cycle.
//  Generalises the single-bit compare to WIDTH bits with per-transaction signed/unsigned mode.
//  Uses valid/ready handshakes on both sides; sits between operand registers and branch/ALU flag logic.
// PARAMETERS
//  WIDTH   32  operand width in bits, >=1
//  DIGIT    4  bits compared per cycle, 1..WIDTH; NCHUNK = ceil(WIDTH/DIGIT)
// PORTS
//  clock            in   1      single clock, rising edge
//  resetN           in   1      asynchronous, active-low reset
//  inValid          in   1      operands and mode presented
//  inReady          out  1      block can accept; high only in IDLE
//  dataA            in   WIDTH  operand A
//  dataB            in   WIDTH  operand B
//  twosComplement   in   1      1 = signed compare, 0 = unsigned; sampled at accept
//  outValid         out  1      result valid; held until outReady
//  outReady         in   1      consumer takes result
//  aEqualsB         out  1      A == B
//  aGreaterThanB    out  1      A > B
//  aLessThanB       out  1      A < B
// BEHAVIOUR
//  - Reset (async, resetN=0): state IDLE; inReady=1 after release; outValid, aEqualsB,
//    aGreaterThanB, aLessThanB = 0; operand registers cleared. Reset mid-RUN/DONE discards the transaction.
//  - States: IDLE -> RUN on accept (inValid & inReady); RUN -> DONE after the last chunk is
//    processed; DONE -> IDLE on outReady & outValid. No other transitions.
//  - Accept: latch dataA, dataB; if twosComplement, invert bit WIDTH-1 of both (offset-binary),
//    then zero-extend at MSB to NCHUNK*DIGIT bits; clear chunk index; decision = EQ.
//  - RUN: each cycle compare chunk NCHUNK-1-k (MSB first); first unequal chunk fixes GT/LT;
//    subsequent chunks do not alter a fixed decision.
//  - Latency: outValid rises NCHUNK cycles after the accept edge (fixed, mode-independent).
//  - Exactly one of aEqualsB/aGreaterThanB/aLessThanB is 1 while outValid=1; outputs are registered
//    and stable until outValid falls; they return to 0 on leaving DONE.
//  - Throughput: one transaction per NCHUNK+2 cycles minimum; inReady=0 in RUN and DONE,
//    inValid there is ignored (no buffering).
//  - Backpressure: outReady=0 holds DONE indefinitely; outReady while outValid=0 is ignored.
//  - WIDTH=1 signed: single bit is sign; 1 (= -1) < 0.
// CONFIGURATION
//  SERIAL_CMP_EARLY_EXIT_EN defined: RUN exits to DONE on the cycle the first unequal chunk
//    is seen; outValid rises k+1 cycles after accept (k = zero-based MSB-first index of that chunk);
//    equal operands still take NCHUNK cycles.
//  Not defined: fixed NCHUNK-cycle latency for every transaction (constant-time).
// STRUCTURE
//  - Shared package cmp_pkg: state encoding (IDLE/RUN/DONE), function nchunk(WIDTH,DIGIT),
//    decision encoding (EQ/GT/LT).
//  - One sub-module: digit_comparator (combinational, DIGIT bits -> eq/gt/lt), instanced once.
//  - Top: FSM, chunk index counter ($clog2(NCHUNK) bits, min 1), operand shift/select, result regs.
// TESTING
//  - Unsigned WIDTH=32 DIGIT=4: A=0x80000000, B=0x7FFFFFFF, twos=0 -> GT after 8 cycles.
//  - Same operands, twos=1 -> LT (A negative); outValid exactly 8 cycles after accept.
//  - A=B=0xDEADBEEF -> EQ only; with EARLY_EXIT_EN still 8 cycles.
//  - EARLY_EXIT_EN: A=0x10000000, B=0x00000000 -> GT, outValid 1 cycle after accept;
//    without macro -> 8 cycles.
//  - Backpressure: hold outReady=0 for 5 cycles -> result and outValid stable, inReady=0;
//    raise outReady -> IDLE next cycle.
//  - resetN low mid-RUN -> all outputs 0 immediately; new transaction after release
//    completes correctly; WIDTH=10 DIGIT=4 (partial top chunk) A=0x3FF, B=0x200 unsigned -> GT.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  typedef enum logic [1:0] {DEC_EQ, DEC_GT, DEC_LT} dec_t;

  function automatic int nchunk(input int width, input int digit);
    return (width + digit - 1) / digit;
  endfunction

  function automatic int idx_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_comparator.sv
// Combinational unsigned compare of one DIGIT-bit chunk.
module digit_comparator #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_eq,
  output logic             o_gt,
  output logic             o_lt
);

  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a >  i_b);
  assign o_lt = (i_a <  i_b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first multi-cycle magnitude comparator, DIGIT bits per cycle, signed/unsigned per transaction.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first unequal chunk instead of constant time.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             twosComplement,
  output logic             outValid,
  input  logic             outReady,
  output logic             aEqualsB,
  output logic             aGreaterThanB,
  output logic             aLessThanB
);

  localparam int NCHUNK = nchunk(WIDTH, DIGIT);
  localparam int PW     = NCHUNK * DIGIT;
  localparam int CW     = idx_bits(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t          r_state;
  dec_t            r_dec;
  logic [PW-1:0]   r_a, r_b;
  logic [CW-1:0]   r_idx;
  logic            r_out_valid, r_eq, r_gt, r_lt;

  logic [WIDTH-1:0] w_flip;
  logic [PW-1:0]    w_a_ext, w_b_ext;
  logic             w_eq, w_gt, w_lt, w_last, w_finish;
  dec_t             w_dec_nxt;

  // Flipping the sign bit maps two's complement onto offset binary, so one unsigned compare serves both modes.
  assign w_flip  = WIDTH'(twosComplement) << (WIDTH - 1);
  assign w_a_ext = PW'(dataA ^ w_flip);
  assign w_b_ext = PW'(dataB ^ w_flip);

  digit_comparator #(.DIGIT(DIGIT)) u_digit (
    .i_a  (r_a[PW-1 -: DIGIT]),
    .i_b  (r_b[PW-1 -: DIGIT]),
    .o_eq (w_eq),
    .o_gt (w_gt),
    .o_lt (w_lt)
  );

  always_comb begin
    w_dec_nxt = r_dec;
    if (r_dec == DEC_EQ && !w_eq)
      w_dec_nxt = w_gt ? DEC_GT : DEC_LT;
  end

  assign w_last = (r_idx == LAST);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_finish = w_last || (w_dec_nxt != DEC_EQ);
`else
  assign w_finish = w_last;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state     <= ST_IDLE;
      r_dec       <= DEC_EQ;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
      r_lt        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (inValid) begin
          r_a     <= w_a_ext;
          r_b     <= w_b_ext;
          r_idx   <= '0;
          r_dec   <= DEC_EQ;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_dec <= w_dec_nxt;
          r_a   <= r_a << DIGIT;
          r_b   <= r_b << DIGIT;
          r_idx <= r_idx + 1'b1;
          if (w_finish) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_eq        <= (w_dec_nxt == DEC_EQ);
            r_gt        <= (w_dec_nxt == DEC_GT);
            r_lt        <= (w_dec_nxt == DEC_LT);
          end
        end
        ST_DONE: if (outReady) begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_eq        <= 1'b0;
          r_gt        <= 1'b0;
          r_lt        <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign inReady       = (r_state == ST_IDLE);
  assign outValid      = r_out_valid;
  assign aEqualsB      = r_eq;
  assign aGreaterThanB = r_gt;
  assign aLessThanB    = r_lt;

endmodule
